register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - 32 x 32-bit integer register file for the RISC-V core; sink end of the writeback interface driven by the data memory stage (write_req/write_addr/write_data) plus the ALU writeback.
// - Supplies registered src1/src2 operands to execute with write-to-read bypass.
// - Keeps a pending-load scoreboard and raises stall while a source register awaits its load data.
// PARAMETERS
// - XLEN        32   data width of every register and port
// - RESET_VALUE 0    value loaded into x1..x31 on reset
// PORTS
// - clk             in   1     core clock, all state on rising edge
// - reset_n         in   1     asynchronous active-low reset
// - read_enable     in   1     decode requests operands this cycle
// - rs1_addr        in   5     source 1 index
// - rs2_addr        in   5     source 2 index
// - src1_value      out  XLEN  registered source 1 operand
// - src2_value      out  XLEN  registered source 2 operand
// - stall           out  1     combinational: requested source awaits a load
// - load_issue      in   1     a load with destination load_rd enters memory stage
// - load_rd         in   5     destination of issued load
// - alu_write_req   in   1     ALU writeback valid
// - alu_write_addr  in   5     ALU destination
// - alu_write_data  in   XLEN  ALU result
// - write_req       in   1     memory-stage writeback valid (load data)
// - write_addr      in   5     load destination
// - write_data      in   XLEN  load data
// BEHAVIOUR
// - Reset (async, reset_n low): x1..x31 <= RESET_VALUE; src1_value, src2_value <= 0; pending[31:0] <= 0, so stall = 0. Takes effect immediately, mid-operation included; pending loads are dropped.
// - x0: reads always return 0; writes to index 0 are ignored; pending[0] is never set.
// - Writes, rising edge:
//   - alu_write_req=1 writes regs[alu_write_addr].
//   - write_req=1 writes regs[write_addr].
//   - Both to the same nonzero index: ALU data is stored (younger instruction wins).
// - Reads, 1-cycle latency: with read_enable=1 and stall=0, srcN_value <= operand(rsN_addr) at the edge. Otherwise srcN_value holds.
// - operand(a) bypass priority:
//   - a==0 -> 0.
//   - alu_write_req && alu_write_addr==a -> alu_write_data.
//   - write_req && write_addr==a -> write_data.
//   - else regs[a].
// - Scoreboard, per index i != 0:
//   - set when load_issue && load_rd==i;
//   - cleared when write_req && write_addr==i;
//   - simultaneous set and clear on the same i -> set wins (new load).
//   - An ALU write to a pending i does not clear it.
// - stall = read_enable && ((pending[rs1_addr] && !clr(rs1_addr)) || (pending[rs2_addr] && !clr(rs2_addr))), where clr(a) = write_req && write_addr==a.
//   - The writeback cycle therefore does not stall; the data is bypassed.
//   - stall does not look at same-cycle load_issue.
// - No overflow or wrap: all arithmetic is index compare only. Widths are fixed at 5-bit index and XLEN data.
// TESTING
// - Reset, then read x5/x0 -> src1=RESET_VALUE, src2=0, stall=0. Write x0=0xDEAD, read x0 -> 0.
// - ALU write x3=0x1234 and read rs1=3 in the same cycle -> src1_value=0x1234 next cycle. Later read still 0x1234.
// - Same edge: ALU x7=0xAAAA and memory x7=0x5555 -> read x7 = 0xAAAA.
// - load_issue rd=9, next cycle read rs2=9 -> stall=1 each cycle until write_req x9=0xCAFE. That cycle stall=0 and src2_value=0xCAFE next cycle.
// - load_issue rd=4 and write_req x4 on the same edge -> pending[4] stays 1 and a read of x4 stalls.
// - Set pending x12, pulse reset_n low mid-stall -> stall=0 immediately, outputs 0, x12=RESET_VALUE.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32 x XLEN integer register file with write-to-read bypass
// and a pending-load scoreboard that raises stall for unresolved sources.
// Each architectural register x1..x31 is one register_file_entry instance;
// x0 is hard-wired to zero and can never be marked pending.

module register_file_entry #(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_VALUE = '0,
    parameter int unsigned      IDX         = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_alu_write_req,
    input  logic [4:0]      i_alu_write_addr,
    input  logic [XLEN-1:0] i_alu_write_data,
    input  logic            i_write_req,
    input  logic [4:0]      i_write_addr,
    input  logic [XLEN-1:0] i_write_data,
    input  logic            i_load_issue,
    input  logic [4:0]      i_load_rd,
    output logic [XLEN-1:0] o_value,
    output logic            o_pending
);
    localparam logic [4:0] ADDR = 5'(IDX);

    logic            w_alu_hit;
    logic            w_mem_hit;
    logic            w_load_hit;
    logic [XLEN-1:0] r_value;
    logic            r_pending;

    assign w_alu_hit  = i_alu_write_req && (i_alu_write_addr == ADDR);
    assign w_mem_hit  = i_write_req     && (i_write_addr     == ADDR);
    assign w_load_hit = i_load_issue    && (i_load_rd        == ADDR);

    // Register value: ALU result beats load data, it belongs to the younger instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_value <= RESET_VALUE;
        else if (w_alu_hit)
            r_value <= i_alu_write_data;
        else if (w_mem_hit)
            r_value <= i_write_data;
    end

    // Pending flag: a new load wins over a same-cycle writeback; ALU writes never clear it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pending <= 1'b0;
        else if (w_load_hit)
            r_pending <= 1'b1;
        else if (w_mem_hit)
            r_pending <= 1'b0;
    end

    assign o_value   = r_value;
    assign o_pending = r_pending;
endmodule

module register_file #(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            read_enable,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] src1_value,
    output logic [XLEN-1:0] src2_value,
    output logic            stall,
    input  logic            load_issue,
    input  logic [4:0]      load_rd,
    input  logic            alu_write_req,
    input  logic [4:0]      alu_write_addr,
    input  logic [XLEN-1:0] alu_write_data,
    input  logic            write_req,
    input  logic [4:0]      write_addr,
    input  logic [XLEN-1:0] write_data
);
    localparam int unsigned NUM_REGS = 32;

    logic [NUM_REGS-1:0][XLEN-1:0] w_regs;
    logic [NUM_REGS-1:0]           w_pending;
    logic [XLEN-1:0]               w_op1;
    logic [XLEN-1:0]               w_op2;
    logic                          w_clr1;
    logic                          w_clr2;
    logic                          w_wait1;
    logic                          w_wait2;
    logic [XLEN-1:0]               r_src1;
    logic [XLEN-1:0]               r_src2;

    // x0 is constant zero and never pending
    assign w_regs[0]    = '0;
    assign w_pending[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
        register_file_entry #(
            .XLEN        (XLEN),
            .RESET_VALUE (RESET_VALUE),
            .IDX         (g)
        ) u_entry (
            .clk              (clk),
            .reset_n          (reset_n),
            .i_alu_write_req  (alu_write_req),
            .i_alu_write_addr (alu_write_addr),
            .i_alu_write_data (alu_write_data),
            .i_write_req      (write_req),
            .i_write_addr     (write_addr),
            .i_write_data     (write_data),
            .i_load_issue     (load_issue),
            .i_load_rd        (load_rd),
            .o_value          (w_regs[g]),
            .o_pending        (w_pending[g])
        );
    end

    // Operand with same-cycle bypass: ALU writeback first, then load data, then storage
    function automatic logic [XLEN-1:0] operand(
        input logic [4:0]                    a,
        input logic [NUM_REGS-1:0][XLEN-1:0] regs,
        input logic                          alu_req,
        input logic [4:0]                    alu_addr,
        input logic [XLEN-1:0]               alu_data,
        input logic                          mem_req,
        input logic [4:0]                    mem_addr,
        input logic [XLEN-1:0]               mem_data
    );
        if (a == 5'd0)
            return '0;
        else if (alu_req && (alu_addr == a))
            return alu_data;
        else if (mem_req && (mem_addr == a))
            return mem_data;
        else
            return regs[a];
    endfunction

    // Bypassed operand selection for both source ports
    always_comb begin
        w_op1 = operand(rs1_addr, w_regs, alu_write_req, alu_write_addr, alu_write_data,
                        write_req, write_addr, write_data);
        w_op2 = operand(rs2_addr, w_regs, alu_write_req, alu_write_addr, alu_write_data,
                        write_req, write_addr, write_data);
    end

    // A source waiting on a load stops stalling in the cycle its data arrives (it is bypassed)
    always_comb begin
        w_clr1  = write_req && (write_addr == rs1_addr);
        w_clr2  = write_req && (write_addr == rs2_addr);
        w_wait1 = w_pending[rs1_addr] && !w_clr1;
        w_wait2 = w_pending[rs2_addr] && !w_clr2;
        stall   = read_enable && (w_wait1 || w_wait2);
    end

    // Operand registers: capture only on an unstalled read, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (read_enable && !stall) begin
            r_src1 <= w_op1;
            r_src2 <= w_op2;
        end
    end

    assign src1_value = r_src1;
    assign src2_value = r_src2;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven directed vectors for register_file plus a
// hand-written reset-during-stall sequence.

module tb_register_file;
    localparam int unsigned   XLEN = 32;
    localparam logic [31:0]   RV   = 32'h5A5A_0001;

    logic            clk;
    logic            reset_n;
    logic            read_enable;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [31:0]     src1_value;
    logic [31:0]     src2_value;
    logic            stall;
    logic            load_issue;
    logic [4:0]      load_rd;
    logic            alu_write_req;
    logic [4:0]      alu_write_addr;
    logic [31:0]     alu_write_data;
    logic            write_req;
    logic [4:0]      write_addr;
    logic [31:0]     write_data;

    int checks;
    int failures;

    register_file #(.XLEN(XLEN), .RESET_VALUE(RV)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .read_enable    (read_enable),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .src1_value     (src1_value),
        .src2_value     (src2_value),
        .stall          (stall),
        .load_issue     (load_issue),
        .load_rd        (load_rd),
        .alu_write_req  (alu_write_req),
        .alu_write_addr (alu_write_addr),
        .alu_write_data (alu_write_data),
        .write_req      (write_req),
        .write_addr     (write_addr),
        .write_data     (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        li;
        logic [4:0]  lrd;
        logic        aw;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mw;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        exp_stall;
        logic [31:0] exp_src1;
        logic [31:0] exp_src2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        read_enable    = v.re;
        rs1_addr       = v.rs1;
        rs2_addr       = v.rs2;
        load_issue     = v.li;
        load_rd        = v.lrd;
        alu_write_req  = v.aw;
        alu_write_addr = v.aa;
        alu_write_data = v.ad;
        write_req      = v.mw;
        write_addr     = v.ma;
        write_data     = v.md;
    endtask

    function automatic vec_t mk(logic re, logic [4:0] rs1, logic [4:0] rs2,
                                logic li, logic [4:0] lrd,
                                logic aw, logic [4:0] aa, logic [31:0] ad,
                                logic mw, logic [4:0] ma, logic [31:0] md,
                                logic es, logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.re = re; v.rs1 = rs1; v.rs2 = rs2; v.li = li; v.lrd = lrd;
        v.aw = aw; v.aa = aa; v.ad = ad; v.mw = mw; v.ma = ma; v.md = md;
        v.exp_stall = es; v.exp_src1 = e1; v.exp_src2 = e2;
        return v;
    endfunction

    initial begin
        vec_t idle;
        checks   = 0;
        failures = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        reset_n = 1'b0;
        #12;
        chk("reset_src1", src1_value, 32'h0);
        chk("reset_src2", src2_value, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        //           re rs1 rs2 li lrd aw aa ad            mw ma md            stall src1          src2
        vecs.push_back(mk(1, 5, 0,  0, 0,  0, 0, 0,            0, 0, 0,            0, RV,           0));
        vecs.push_back(mk(1, 0, 5,  0, 0,  1, 0, 32'hDEAD,     1, 0, 32'hBEEF,     0, 0,            RV));
        vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0, 0,            0, 0, 0,            0, 0,            0));
        vecs.push_back(mk(1, 3, 0,  0, 0,  1, 3, 32'h1234,     0, 0, 0,            0, 32'h1234,     0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,            0, 0, 0,            0, 32'h1234,     0));
        vecs.push_back(mk(1, 0, 3,  0, 0,  0, 0, 0,            0, 0, 0,            0, 0,            32'h1234));
        vecs.push_back(mk(1, 7, 7,  0, 0,  1, 7, 32'hAAAA,     1, 7, 32'h5555,     0, 32'hAAAA,     32'hAAAA));
        vecs.push_back(mk(1, 7, 3,  0, 0,  0, 0, 0,            0, 0, 0,            0, 32'hAAAA,     32'h1234));
        vecs.push_back(mk(1, 9, 3,  1, 9,  0, 0, 0,            0, 0, 0,            0, RV,           32'h1234));
        vecs.push_back(mk(1, 0, 9,  0, 0,  0, 0, 0,            0, 0, 0,            1, RV,           32'h1234));
        vecs.push_back(mk(1, 0, 9,  0, 0,  1, 9, 32'h1111,     0, 0, 0,            1, RV,           32'h1234));
        vecs.push_back(mk(1, 0, 9,  0, 0,  0, 0, 0,            1, 9, 32'hCAFE,     0, 0,            32'hCAFE));
        vecs.push_back(mk(1, 9, 9,  0, 0,  0, 0, 0,            0, 0, 0,            0, 32'hCAFE,     32'hCAFE));
        vecs.push_back(mk(0, 0, 0,  1, 4,  0, 0, 0,            1, 4, 32'h4444,     0, 32'hCAFE,     32'hCAFE));
        vecs.push_back(mk(1, 4, 0,  0, 0,  0, 0, 0,            0, 0, 0,            1, 32'hCAFE,     32'hCAFE));
        vecs.push_back(mk(1, 4, 0,  0, 0,  0, 0, 0,            1, 4, 32'h4545,     0, 32'h4545,     0));
        vecs.push_back(mk(1, 10, 4, 0, 0,  0, 0, 0,            1, 10, 32'h1010,    0, 32'h1010,     32'h4545));
        vecs.push_back(mk(1, 0, 0,  1, 0,  0, 0, 0,            0, 0, 0,            0, 0,            0));
        vecs.push_back(mk(1, 0, 10, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0,            32'h1010));
        vecs.push_back(mk(1, 10, 3, 1, 12, 0, 0, 0,            0, 0, 0,            0, 32'h1010,     32'h1234));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_src1", i), src1_value, vecs[i].exp_src1);
            chk($sformatf("v%0d_src2", i), src2_value, vecs[i].exp_src2);
            drive(idle);
        end

        // Reset asserted while a read of pending x12 is stalling
        #1;
        drive(mk(1, 12, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_reset_stall", {31'b0, stall}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_stall", {31'b0, stall}, 32'h0);
        chk("mid_reset_src1", src1_value, 32'h0);
        chk("mid_reset_src2", src2_value, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_reset_x12", src1_value, RV);
        chk("post_reset_x3", src2_value, RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
